// File: rtl/alu_cmd_responder.sv
// Command-driven 32-bit accumulator ALU. Commands come in and responses go out on two
// valid/ready channels. POW uses an iterative multiplier and DIV uses a restoring divider.
module alu_cmd_responder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_p,
   input  logic [WIDTH-1:0] cmd_q,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [1:0]       rsp_error,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_CLR = 4'b1100;
   localparam logic [3:0] OP_POW = 4'b1111;

   localparam logic [1:0] ERR_OK  = 2'b00;
   localparam logic [1:0] ERR_OVF = 2'b01;
   localparam logic [1:0] ERR_DIV = 2'b10;
   localparam logic [1:0] ERR_ILL = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

   stateT state, nextState;

   logic [WIDTH-1:0] acc;
   logic [1:0]       err;
   logic [WIDTH-1:0] opP;
   logic [WIDTH-1:0] tmp;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [CW-1:0]    cnt;
   logic             isDiv;
   logic             ovf;

   logic             accept;
   logic             startExec;
   logic             execDone;
   logic [WIDTH-1:0] immAcc;
   logic [1:0]       immErr;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] powProd;
   logic [WIDTH-1:0] powNext;
   logic             powOvf;
   logic [WIDTH:0]   remShift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] newRem;
   logic [WIDTH-1:0] newQuo;

   assign accept   = cmd_valid && (state == IDLE);
   assign execDone = (cnt == CW'(1));

   // Immediate result of the command being accepted; decides whether an engine must run
   always_comb begin
      sum       = {1'b0, acc} + {1'b0, cmd_p};
      diff      = {1'b0, acc} - {1'b0, cmd_p};
      prod      = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, cmd_p};
      immAcc    = acc;
      immErr    = ERR_OK;
      startExec = 1'b0;
      case (cmd_op)
         OP_NOP: immAcc = acc;
         OP_ADD: begin
            immAcc = sum[WIDTH-1:0];
            immErr = sum[WIDTH] ? ERR_OVF : ERR_OK;
         end
         OP_SUB: begin
            immAcc = diff[WIDTH-1:0];
            immErr = diff[WIDTH] ? ERR_OVF : ERR_OK;
         end
         OP_MUL: begin
            immAcc = prod[WIDTH-1:0];
            immErr = (|prod[2*WIDTH-1:WIDTH]) ? ERR_OVF : ERR_OK;
         end
         OP_DIV: begin
            if (cmd_p == '0) immErr = ERR_DIV;
            else startExec = 1'b1;
         end
         OP_CLR: immAcc = '0;
         OP_POW: begin
            if (|cmd_q[WIDTH-1:5]) immErr = ERR_ILL;
            else if (cmd_q == '0) immAcc = WIDTH'(1);
            else startExec = 1'b1;
         end
         default: immErr = ERR_ILL;
      endcase
   end

   // One engine step: a multiply for POW, one restoring-division bit for DIV
   always_comb begin
      powProd  = {{WIDTH{1'b0}}, tmp} * {{WIDTH{1'b0}}, opP};
      powNext  = powProd[WIDTH-1:0];
      powOvf   = ovf | (|powProd[2*WIDTH-1:WIDTH]);
      remShift = {rem, quo[WIDTH-1]};
      trial    = remShift - {1'b0, opP};
      if (!trial[WIDTH]) begin
         newRem = trial[WIDTH-1:0];
         newQuo = {quo[WIDTH-2:0], 1'b1};
      end else begin
         newRem = remShift[WIDTH-1:0];
         newQuo = {quo[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (accept) nextState = startExec ? EXEC : RESP;
         end
         EXEC: begin
            if (execDone) nextState = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Datapath: the accumulator commits on the edge that enters RESP
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         err   <= ERR_OK;
         opP   <= '0;
         tmp   <= '0;
         quo   <= '0;
         rem   <= '0;
         cnt   <= '0;
         isDiv <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (startExec) begin
                     opP   <= cmd_p;
                     isDiv <= (cmd_op == OP_DIV);
                     ovf   <= 1'b0;
                     rem   <= '0;
                     quo   <= acc;
                     tmp   <= WIDTH'(1);
                     if (cmd_op == OP_DIV) cnt <= CW'(WIDTH);
                     else                  cnt <= CW'(cmd_q[4:0]);
                  end else begin
                     acc <= immAcc;
                     err <= immErr;
                  end
               end
            end
            EXEC: begin
               cnt <= cnt - CW'(1);
               if (isDiv) begin
                  rem <= newRem;
                  quo <= newQuo;
                  if (execDone) begin
                     acc <= newQuo;
                     err <= ERR_OK;
                  end
               end else begin
                  tmp <= powNext;
                  ovf <= powOvf;
                  if (execDone) begin
                     acc <= powNext;
                     err <= powOvf ? ERR_OVF : ERR_OK;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_result = acc;
   assign rsp_error  = err;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Self-checking bench for alu_cmd_responder: directed scenarios followed by random commands,
// all compared against an arithmetic model of the accumulator.
module tb_alu_cmd_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_op;
   logic [31:0] cmd_p;
   logic [31:0] cmd_q;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_result;
   logic [1:0]  rsp_error;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] modelAcc = 32'd0;

   alu_cmd_responder #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_p(cmd_p), .cmd_q(cmd_q),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference: what the accumulator, error code and engine cycle count should be
   task automatic modelCmd(input logic [3:0] op, input logic [31:0] p, input logic [31:0] q,
                           output logic [31:0] res, output logic [1:0] err, output int lat);
      longint unsigned full;
      longint unsigned t;
      bit big;
      res = modelAcc; err = 2'b00; lat = 0;
      case (op)
         4'b0000: ;
         4'b0001: begin
            full = longint'(modelAcc) + longint'(p);
            res = full[31:0]; err = (full >= 64'h1_0000_0000) ? 2'b01 : 2'b00;
         end
         4'b0100: begin
            res = modelAcc - p; err = (p > modelAcc) ? 2'b01 : 2'b00;
         end
         4'b0010: begin
            full = longint'(modelAcc) * longint'(p);
            res = full[31:0]; err = (full >= 64'h1_0000_0000) ? 2'b01 : 2'b00;
         end
         4'b0011: begin
            if (p == 0) err = 2'b10;
            else begin res = modelAcc / p; lat = 32; end
         end
         4'b1100: res = 32'd0;
         4'b1111: begin
            if (q > 31) err = 2'b11;
            else begin
               t = 1; big = 0;
               for (int i = 0; i < int'(q); i++) begin
                  t = t * longint'(p);
                  if (t >= 64'h1_0000_0000) big = 1;
                  t = t & 64'hFFFF_FFFF;
               end
               res = t[31:0]; err = big ? 2'b01 : 2'b00; lat = int'(q);
            end
         end
         default: err = 2'b11;
      endcase
   endtask

   // Issue one command, verify latency, held response under backpressure, and handshake
   task automatic applyStimulus(input string tag, input logic [3:0] op, input logic [31:0] p,
                                input logic [31:0] q, input int rspDelay);
      logic [31:0] expRes;
      logic [1:0]  expErr;
      int expLat;
      int k;
      modelCmd(op, p, q, expRes, expErr, expLat);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_p = p; cmd_q = q;
      rsp_ready = (rspDelay == 0);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_p = $urandom; cmd_q = $urandom; cmd_op = 4'($urandom);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
      k = 0;
      while (!rsp_valid && k < 100) begin
         @(negedge clk);
         k++;
      end
      checkOutput({tag, ".latency"}, 32'(k), 32'(expLat));
      checkOutput({tag, ".result"}, rsp_result, expRes);
      checkOutput({tag, ".error"}, 32'(rsp_error), 32'(expErr));
      for (int d = 0; d < rspDelay; d++) begin
         if (d == rspDelay / 2) begin
            cmd_valid = 1'b1; cmd_op = 4'b1100;
         end
         @(negedge clk);
         cmd_valid = 1'b0;
         checkOutput({tag, ".heldValid"}, 32'(rsp_valid), 32'd1);
         checkOutput({tag, ".heldResult"}, rsp_result, expRes);
         checkOutput({tag, ".heldReady"}, 32'(cmd_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput({tag, ".postValid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".postReady"}, 32'(cmd_ready), 32'd1);
      modelAcc = expRes;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".cmdReady"}, 32'(cmd_ready), 32'd1);
      checkOutput({tag, ".rspValid"}, 32'(rsp_valid), 32'd0);
      checkOutput({tag, ".rspResult"}, rsp_result, 32'd0);
      checkOutput({tag, ".rspError"}, 32'(rsp_error), 32'd0);
      checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [3:0] opTable [9];
      logic [3:0] rop;
      logic [31:0] rp;
      logic [31:0] rq;
      opTable = '{4'b0000, 4'b0001, 4'b0100, 4'b0010, 4'b0011, 4'b1100, 4'b1111, 4'b0111, 4'b0101};
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_p = '0; cmd_q = '0; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetState("reset");
      rst = 1'b0;

      // Circle area chain
      applyStimulus("circClr", 4'b1100, 32'd0, 32'd0, 0);
      applyStimulus("circPow", 4'b1111, 32'd12, 32'd2, 0);
      checkOutput("circPowVal", modelAcc, 32'd144);
      applyStimulus("circMul", 4'b0010, 32'd3141, 32'd0, 1);
      applyStimulus("circDiv", 4'b0011, 32'd1000, 32'd0, 0);
      checkOutput("circDivVal", modelAcc, 32'd452);

      // Divide by zero then recovery
      applyStimulus("divZero", 4'b0011, 32'd0, 32'd0, 0);
      applyStimulus("addAfter", 4'b0001, 32'd8, 32'd0, 0);

      // Overflow and underflow
      applyStimulus("ovfClr", 4'b1100, 32'd0, 32'd0, 0);
      applyStimulus("ovfSet", 4'b0001, 32'h8000_0000, 32'd0, 0);
      applyStimulus("mulOvf", 4'b0010, 32'd2, 32'd0, 0);
      applyStimulus("subUnd", 4'b0100, 32'd1, 32'd0, 0);
      applyStimulus("addCarry", 4'b0001, 32'd2, 32'd0, 0);

      // Backpressure with a stray command pulse in the middle
      applyStimulus("backPress", 4'b0001, 32'd5, 32'd0, 10);

      // Reset in the middle of a divide
      applyStimulus("rdClr", 4'b1100, 32'd0, 32'd0, 0);
      applyStimulus("rdSet", 4'b0001, 32'd700, 32'd0, 0);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'b0011; cmd_p = 32'd7; rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      checkOutput("midDivBusy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      checkResetState("midDivReset");
      @(negedge clk);
      rst = 1'b0; rsp_ready = 1'b0;
      modelAcc = 32'd0;
      applyStimulus("rdAdd", 4'b0001, 32'd3, 32'd0, 0);

      // Illegal opcode and POW corner cases
      applyStimulus("illegal", 4'b0111, 32'd99, 32'd0, 0);
      applyStimulus("powQ0", 4'b1111, 32'd5, 32'd0, 0);
      applyStimulus("powQ40", 4'b1111, 32'd2, 32'd40, 0);
      applyStimulus("powQ31", 4'b1111, 32'd2, 32'd31, 0);
      applyStimulus("powQ32", 4'b1111, 32'd2, 32'd32, 0);
      applyStimulus("powOvf", 4'b1111, 32'd3, 32'd25, 0);

      // Random command stream
      for (int n = 0; n < 40; n++) begin
         rop = opTable[$urandom_range(0, 8)];
         rp  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         rq  = 32'($urandom_range(0, 40));
         applyStimulus("rand", rop, rp, rq, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_cmd_responder.md
# alu_cmd_responder

Command-driven accumulator ALU that sits on the responder side of the calculator command interface. The Python middleware, or an on-chip sequencer, issues (opcode, P, Q) commands over a valid/ready channel. The block executes each command against a 32-bit internal accumulator, using multi-cycle engines where needed. It returns one (result, error) response per command over a second valid/ready channel, so equations such as circle area are built from chained commands.

## Interface
- WIDTH, 32, operand/accumulator/result width (unsigned)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  4  opcode
- cmd_p  input  WIDTH  operand P
- cmd_q  input  WIDTH  operand Q (POW exponent only)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer takes response
- rsp_result  output  WIDTH  accumulator value after the command
- rsp_error  output  2  00 ok, 01 overflow/underflow, 10 divide-by-zero, 11 illegal
- busy  output  1  high outside IDLE

## Operation
- Opcodes (all unsigned):
  - 0000 NOP: acc unchanged.
  - 0001 ADD: acc=acc+P.
  - 0100 SUB: acc=acc−P.
  - 0010 MUL: acc=acc×P.
  - 0011 DIV: acc=acc/P (quotient).
  - 1100 CLR: acc=0.
  - 1111 POW: acc=P^Q.
  - Any other opcode: illegal.
- Overflow and underflow:
  - ADD carry-out → error 01; acc gets the low WIDTH bits.
  - SUB borrow → error 01; acc wraps.
  - MUL with a nonzero upper half of the 2×WIDTH product → error 01; acc gets the low half.
- POW:
  - Q=0 gives acc=1.
  - Q[WIDTH-1:5]≠0 → error 11; acc unchanged.
  - Otherwise iterative: tmp=1, then Q multiplies by P, one per cycle.
  - Overflow is sticky across iterations. Final acc is the truncated product with error 01.
- DIV:
  - P=0 → error 10; acc unchanged.
  - Otherwise a restoring divider, one quotient bit per cycle, WIDTH cycles.
- Illegal opcode → error 11; acc unchanged.
- FSM:
  - IDLE → (cmd_valid&cmd_ready) → EXEC for POW with Q>0 and DIV with P≠0; RESP for all other commands.
  - EXEC → RESP when the iteration counter expires.
  - RESP → IDLE on rsp_valid&rsp_ready.
- Command operands are registered at acceptance. Later changes on cmd_* have no effect.
- rsp_result equals the committed acc. The accumulator updates at the cycle edge where RESP is entered.

## Timing
- Reset values:
  - FSM IDLE, acc=0.
  - cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_error=00, busy=0.
  - EXEC counters cleared.
- cmd_ready=1 only in IDLE.
- A command handshake occurs at edge N. Latency to rsp_valid:
  - Single-cycle ops, CLR, NOP, illegal, and error-shortcut cases: rsp_valid high after edge N+1.
  - POW: high after edge N+1+Q.
  - DIV: high after edge N+1+WIDTH (N+33).
- rsp_valid, rsp_result and rsp_error are held stable until the rsp handshake edge.
- After the rsp handshake edge, rsp_valid=0 and cmd_ready=1 in the following cycle. A command is never accepted in the same cycle as a response handshake.
- Maximum throughput is one command per 2 cycles.
- rsp_ready held high while waiting adds no latency. rsp_ready low holds the block in RESP indefinitely.
- Reset asserted mid-EXEC or mid-RESP:
  - Aborts the operation immediately.
  - Acc returns to 0 and the in-flight response is discarded.
  - All outputs take their reset values asynchronously.
- cmd_valid while busy is ignored. No command is queued.

## Test plan
- Circle area chain: CLR; POW P=12 Q=2 → 144/00 at N+3; MUL P=3141 → 452304/00; DIV P=1000 → 452/00 at N+33.
- Divide by zero: acc=452, DIV P=0 → rsp_result 452, error 10 at N+1. A following ADD P=8 → 460/00.
- Overflow: acc=0x8000_0000, MUL P=2 → 0x0000_0000/01. Then SUB P=1 → 0xFFFF_FFFF/01.
- Backpressure: ADD P=5 with rsp_ready low for 10 cycles → rsp_valid and result stable for all 10 cycles. cmd_ready stays low until 1 cycle after the handshake. A cmd_valid pulse during the wait is not accepted.
- Reset mid-DIV: start DIV P=7 with acc=700, assert rst at cycle 15 → outputs take reset values immediately. The next ADD P=3 → 3/00.
- Illegal and POW edge cases:
  - op 0111 → acc unchanged, error 11.
  - POW P=5 Q=0 → 1/00.
  - POW P=2 Q=40 → error 11.
  - POW P=2 Q=31 → 0x8000_0000/00.
  - POW P=2 Q=32 → error 11.
